// File: rtl/idp_if.sv
// ============================================================================
// Module  : idp_if
// Brief   : Operation/result bundle between the control unit and idp_pipe.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface idp_if #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 3
);
  logic              in_valid;
  logic              stall;
  logic              W_En;
  logic [ADR_W-1:0]  W_Adr;
  logic [ADR_W-1:0]  R_Adr;
  logic [ADR_W-1:0]  S_Adr;
  logic [DATA_W-1:0] DS;
  logic              S_Sel;
  logic [3:0]        ALU_OP;
  logic              rdy;
  logic [DATA_W-1:0] Reg_Out;
  logic [DATA_W-1:0] Alu_Out;
  logic              C;
  logic              N;
  logic              Z;
  logic              out_valid;

  modport master (
    output in_valid, stall, W_En, W_Adr, R_Adr, S_Adr, DS, S_Sel, ALU_OP,
    input  rdy, Reg_Out, Alu_Out, C, N, Z, out_valid
  );

  modport slave (
    input  in_valid, stall, W_En, W_Adr, R_Adr, S_Adr, DS, S_Sel, ALU_OP,
    output rdy, Reg_Out, Alu_Out, C, N, Z, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/idp_pipe.sv
// ============================================================================
// Module  : idp_pipe
// Brief   : 2-stage (EX/WB) integer datapath: register file, S mux, ALU.
//           IDP_FWD_EN defined: EX result bypassed on RAW hazards, rdy tied 1.
//           IDP_FWD_EN undefined: RAW hazard drops rdy for one cycle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module idp_pipe #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8
) (
  input  wire logic clk,
  input  wire logic reset,
  idp_if.slave      bus
);
  localparam int ADR_W = $clog2(REG_CNT);

  localparam logic [3:0] c_op_pass_r = 4'h0;
  localparam logic [3:0] c_op_pass_s = 4'h1;
  localparam logic [3:0] c_op_add    = 4'h2;
  localparam logic [3:0] c_op_sub    = 4'h3;
  localparam logic [3:0] c_op_inc    = 4'h4;
  localparam logic [3:0] c_op_dec    = 4'h5;
  localparam logic [3:0] c_op_and    = 4'h6;
  localparam logic [3:0] c_op_or     = 4'h7;
  localparam logic [3:0] c_op_xor    = 4'h8;
  localparam logic [3:0] c_op_not    = 4'h9;
  localparam logic [3:0] c_op_shl    = 4'hA;
  localparam logic [3:0] c_op_shr    = 4'hB;

  logic [DATA_W-1:0] r_rf [REG_CNT];

  logic              r_ex_valid;
  logic              r_ex_we;
  logic [ADR_W-1:0]  r_ex_wadr;
  logic [3:0]        r_ex_op;
  logic [DATA_W-1:0] r_ex_r;
  logic [DATA_W-1:0] r_ex_s;

  logic              r_wb_valid;
  logic [DATA_W-1:0] r_alu;
  logic              r_c;
  logic              r_n;
  logic              r_z;

  logic [DATA_W-1:0] w_y;
  logic              w_c;
  logic              w_ex_dst_live;
  logic              w_haz_r;
  logic              w_haz_s;
  logic              w_rdy;
  logic              w_accept;
  logic [DATA_W-1:0] w_opr;
  logic [DATA_W-1:0] w_ops;

  // A RAW hazard exists when the op sitting in EX will write a register the incoming op reads.
  assign w_ex_dst_live = r_ex_valid && r_ex_we;
  assign w_haz_r       = w_ex_dst_live && (r_ex_wadr == bus.R_Adr);
  assign w_haz_s       = w_ex_dst_live && !bus.S_Sel && (r_ex_wadr == bus.S_Adr);

`ifdef IDP_FWD_EN
  assign w_rdy = 1'b1;
  assign w_opr = w_haz_r ? w_y : r_rf[bus.R_Adr];
  assign w_ops = bus.S_Sel ? bus.DS : (w_haz_s ? w_y : r_rf[bus.S_Adr]);
`else
  assign w_rdy = !(bus.in_valid && (w_haz_r || w_haz_s));
  assign w_opr = r_rf[bus.R_Adr];
  assign w_ops = bus.S_Sel ? bus.DS : r_rf[bus.S_Adr];
`endif

  assign w_accept = bus.in_valid && w_rdy && !bus.stall;

  always_comb begin
    w_y = r_ex_r;
    w_c = 1'b0;
    case (r_ex_op)
      c_op_pass_r: w_y = r_ex_r;
      c_op_pass_s: w_y = r_ex_s;
      c_op_add:    {w_c, w_y} = {1'b0, r_ex_r} + {1'b0, r_ex_s};
      c_op_sub: begin
        w_y = r_ex_r - r_ex_s;
        w_c = (r_ex_r < r_ex_s);
      end
      c_op_inc:    {w_c, w_y} = {1'b0, r_ex_r} + {{DATA_W{1'b0}}, 1'b1};
      c_op_dec: begin
        w_y = r_ex_r - {{(DATA_W-1){1'b0}}, 1'b1};
        w_c = (r_ex_r == '0);
      end
      c_op_and:    w_y = r_ex_r & r_ex_s;
      c_op_or:     w_y = r_ex_r | r_ex_s;
      c_op_xor:    w_y = r_ex_r ^ r_ex_s;
      c_op_not:    w_y = ~r_ex_r;
      c_op_shl: begin
        w_y = {r_ex_r[DATA_W-2:0], 1'b0};
        w_c = r_ex_r[DATA_W-1];
      end
      c_op_shr: begin
        w_y = {1'b0, r_ex_r[DATA_W-1:1]};
        w_c = r_ex_r[0];
      end
      default:     w_y = r_ex_r;
    endcase
  end

  // EX stage: operands are only reloaded on accept, so Reg_Out holds across bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_valid <= 1'b0;
      r_ex_we    <= 1'b0;
      r_ex_wadr  <= '0;
      r_ex_op    <= '0;
      r_ex_r     <= '0;
      r_ex_s     <= '0;
    end else if (!bus.stall) begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_we   <= bus.W_En;
        r_ex_wadr <= bus.W_Adr;
        r_ex_op   <= bus.ALU_OP;
        r_ex_r    <= w_opr;
        r_ex_s    <= w_ops;
      end
    end
  end

  // WB stage: a bubble clears out_valid but keeps the last result and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_valid <= 1'b0;
      r_alu      <= '0;
      r_c        <= 1'b0;
      r_n        <= 1'b0;
      r_z        <= 1'b0;
    end else if (!bus.stall) begin
      r_wb_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_alu <= w_y;
        r_c   <= w_c;
        r_n   <= w_y[DATA_W-1];
        r_z   <= (w_y == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_CNT; i++) begin
        r_rf[i] <= '0;
      end
    end else if (!bus.stall && r_ex_valid && r_ex_we) begin
      r_rf[r_ex_wadr] <= w_y;
    end
  end

  assign bus.rdy       = w_rdy;
  assign bus.Reg_Out   = r_ex_r;
  assign bus.Alu_Out   = r_alu;
  assign bus.C         = r_c;
  assign bus.N         = r_n;
  assign bus.Z         = r_z;
  assign bus.out_valid = r_wb_valid;

endmodule

`default_nettype wire

// File: tb/tb_idp_pipe.sv
// ============================================================================
// Module  : tb_idp_pipe
// Brief   : Directed and random stimulus for idp_pipe against an in-order model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_idp_pipe;
  localparam int DW = 16;
  localparam int RC = 8;
  localparam int AW = 3;
  localparam int unsigned MOD = 32'd1 << DW;

  logic clk = 1'b0;
  logic reset;

  idp_if #(.DATA_W(DW), .ADR_W(AW)) bus ();

  idp_pipe #(.DATA_W(DW), .REG_CNT(RC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Architectural register state (ops applied in program order at accept).
  logic [DW-1:0] m_rf [RC];
  // Timing slots: what should be in EX and what WB should show.
  bit            m_ex_v;
  bit            m_ex_we;
  logic [AW-1:0] m_ex_wa;
  logic [DW-1:0] m_ex_r;
  logic [DW-1:0] m_ex_y;
  bit            m_ex_c;
  bit            m_ov;
  logic [DW-1:0] m_alu;
  bit            m_c;
  bit            m_n;
  bit            m_z;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void alu_ref(input logic [3:0] op, input int unsigned r, input int unsigned s,
                                  output int unsigned y, output bit c);
    c = 1'b0;
    case (op)
      4'h0: y = r;
      4'h1: y = s;
      4'h2: begin y = (r + s) % MOD; c = (r + s) >= MOD; end
      4'h3: begin y = (r + MOD - s) % MOD; c = (r < s); end
      4'h4: begin y = (r + 1) % MOD; c = (r + 1) >= MOD; end
      4'h5: begin y = (r + MOD - 1) % MOD; c = (r == 0); end
      4'h6: y = r & s;
      4'h7: y = r | s;
      4'h8: y = r ^ s;
      4'h9: y = (MOD - 1) - r;
      4'hA: begin y = (r * 2) % MOD; c = (r >= MOD / 2); end
      4'hB: begin y = r / 2; c = (r % 2) == 1; end
      default: y = r;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RC; i++) m_rf[i] = '0;
    m_ex_v  = 1'b0;
    m_ex_we = 1'b0;
    m_ex_wa = '0;
    m_ex_r  = '0;
    m_ex_y  = '0;
    m_ex_c  = 1'b0;
    m_ov    = 1'b0;
    m_alu   = '0;
    m_c     = 1'b0;
    m_n     = 1'b0;
    m_z     = 1'b0;
  endtask

  task automatic check_outputs();
    check_val("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check_val("alu_out",   32'(bus.Alu_Out),   32'(m_alu));
    check_val("flag_c",    32'(bus.C),         32'(m_c));
    check_val("flag_n",    32'(bus.N),         32'(m_n));
    check_val("flag_z",    32'(bus.Z),         32'(m_z));
    if (m_ex_v) check_val("reg_out", 32'(bus.Reg_Out), 32'(m_ex_r));
  endtask

  // One clock: check registered outputs, drive an op, check rdy, advance the model.
  task automatic step(input bit v, input bit st, input bit we, input logic [AW-1:0] wa,
                      input logic [AW-1:0] ra, input logic [AW-1:0] sa, input logic [DW-1:0] ds,
                      input bit ss, input logic [3:0] op, output bit acc);
    bit            exp_rdy;
    bit            haz;
    int unsigned   y;
    bit            c;
    logic [DW-1:0] opr;
    logic [DW-1:0] ops;
    @(negedge clk);
    check_outputs();
    bus.in_valid = v;
    bus.stall    = st;
    bus.W_En     = we;
    bus.W_Adr    = wa;
    bus.R_Adr    = ra;
    bus.S_Adr    = sa;
    bus.DS       = ds;
    bus.S_Sel    = ss;
    bus.ALU_OP   = op;
    #1;
    haz = m_ex_v && m_ex_we && ((m_ex_wa == ra) || (!ss && (m_ex_wa == sa)));
`ifdef IDP_FWD_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = !(v && haz);
`endif
    check_val("rdy", 32'(bus.rdy), 32'(exp_rdy));
    acc = v && exp_rdy && !st;
    @(posedge clk);
    if (!st) begin
      if (m_ex_v) begin
        m_ov  = 1'b1;
        m_alu = m_ex_y;
        m_c   = m_ex_c;
        m_n   = m_ex_y[DW-1];
        m_z   = (m_ex_y == '0);
      end else begin
        m_ov = 1'b0;
      end
      m_ex_v = acc;
      if (acc) begin
        opr = m_rf[ra];
        ops = ss ? ds : m_rf[sa];
        alu_ref(op, 32'(opr), 32'(ops), y, c);
        m_ex_r  = opr;
        m_ex_y  = DW'(y);
        m_ex_c  = c;
        m_ex_we = we;
        m_ex_wa = wa;
        if (we) m_rf[wa] = DW'(y);
      end
    end
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                       input logic [AW-1:0] sa, input logic [DW-1:0] ds, input bit ss,
                       input logic [3:0] op, output int tries);
    bit acc;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 4) begin
      step(1'b1, 1'b0, we, wa, ra, sa, ds, ss, op, acc);
      tries++;
    end
    if (!acc) check_val("issue_timeout", 32'(tries), 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 4'h0, acc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   tries;
    int   exp_tries;
    bit   acc;
    bit   r_v, r_st, r_we, r_ss;
    logic [AW-1:0] r_wa, r_ra, r_sa;
    logic [DW-1:0] r_ds;
    logic [3:0]    r_op;

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    bus.W_En     = 1'b0;
    bus.W_Adr    = '0;
    bus.R_Adr    = '0;
    bus.S_Adr    = '0;
    bus.DS       = '0;
    bus.S_Sel    = 1'b0;
    bus.ALU_OP   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_alu_out",   32'(bus.Alu_Out),   32'd0);
    check_val("rst_flags",     32'({bus.C, bus.N, bus.Z}), 32'd0);
    check_val("rst_reg_out",   32'(bus.Reg_Out),   32'd0);
    check_val("rst_rdy",       32'(bus.rdy),       32'd1);
    reset = 1'b1;

    // r1 = 5, then r1 + 3
    issue(1'b1, 3'd1, 3'd0, 3'd0, 16'h0005, 1'b1, 4'h1, tries);
    issue(1'b0, 3'd0, 3'd1, 3'd0, 16'h0003, 1'b1, 4'h2, tries);
    idle(1);
    #1;
    check_val("add_valid", 32'(bus.out_valid), 32'd1);
    check_val("add_value", 32'(bus.Alu_Out), 32'h0008);
    check_val("add_flags", 32'({bus.C, bus.N, bus.Z}), 32'b000);

    // 0xFFFF + 1 wraps with carry
    issue(1'b1, 3'd3, 3'd0, 3'd0, 16'hFFFF, 1'b1, 4'h1, tries);
    issue(1'b0, 3'd0, 3'd3, 3'd0, 16'h0001, 1'b1, 4'h2, tries);
    idle(1);
    #1;
    check_val("wrap_value", 32'(bus.Alu_Out), 32'h0000);
    check_val("wrap_flags", 32'({bus.C, bus.N, bus.Z}), 32'b101);

    // 0 - 1 borrows
    issue(1'b1, 3'd4, 3'd0, 3'd0, 16'h0000, 1'b1, 4'h1, tries);
    issue(1'b0, 3'd0, 3'd4, 3'd0, 16'h0001, 1'b1, 4'h3, tries);
    idle(1);
    #1;
    check_val("sub_value", 32'(bus.Alu_Out), 32'hFFFF);
    check_val("sub_flags", 32'({bus.C, bus.N, bus.Z}), 32'b110);

    // shift left of 0x8001
    issue(1'b1, 3'd5, 3'd0, 3'd0, 16'h8001, 1'b1, 4'h1, tries);
    issue(1'b0, 3'd0, 3'd5, 3'd0, 16'h0000, 1'b1, 4'hA, tries);
    idle(1);
    #1;
    check_val("shl_value", 32'(bus.Alu_Out), 32'h0002);
    check_val("shl_carry", 32'(bus.C), 32'd1);

    // back-to-back write r2, then read r2
    issue(1'b1, 3'd2, 3'd0, 3'd0, 16'h1234, 1'b1, 4'h1, tries);
    issue(1'b1, 3'd3, 3'd2, 3'd0, 16'h0000, 1'b0, 4'h4, tries);
`ifdef IDP_FWD_EN
    exp_tries = 1;
`else
    exp_tries = 2;
`endif
    check_val("b2b_tries", 32'(tries), 32'(exp_tries));
    idle(1);
    #1;
    check_val("b2b_value", 32'(bus.Alu_Out), 32'h1235);

    // stall for 3 cycles with ops in EX and WB
    issue(1'b1, 3'd6, 3'd0, 3'd0, 16'h0AAA, 1'b1, 4'h1, tries);
    issue(1'b1, 3'd7, 3'd6, 3'd0, 16'h0055, 1'b1, 4'h7, tries);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 3'd7, 3'd1, 3'd2, 16'hDEAD, 1'b0, 4'h2, acc);
    idle(2);
    issue(1'b0, 3'd0, 3'd7, 3'd0, 16'h0000, 1'b1, 4'h0, tries);
    idle(1);
    #1;
    check_val("stall_r7", 32'(bus.Alu_Out), 32'h0AFF);

    // async reset while a write to r4 sits in EX
    issue(1'b1, 3'd4, 3'd0, 3'd0, 16'h00FF, 1'b1, 4'h1, tries);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    #1;
    check_val("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("arst_alu_out",   32'(bus.Alu_Out),   32'd0);
    check_val("arst_reg_out",   32'(bus.Reg_Out),   32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    issue(1'b0, 3'd0, 3'd4, 3'd0, 16'h0000, 1'b1, 4'h0, tries);
    idle(1);
    #1;
    check_val("arst_r4_valid", 32'(bus.out_valid), 32'd1);
    check_val("arst_r4_zero",  32'(bus.Z), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r_v  = ($urandom_range(0, 3) != 0);
      r_st = ($urandom_range(0, 7) == 0);
      r_we = ($urandom_range(0, 3) != 0);
      r_ss = ($urandom_range(0, 2) == 0);
      r_wa = AW'($urandom_range(0, RC - 1));
      r_ra = AW'($urandom_range(0, RC - 1));
      r_sa = AW'($urandom_range(0, RC - 1));
      r_ds = DW'($urandom);
      r_op = 4'($urandom_range(0, 15));
      step(r_v, r_st, r_we, r_wa, r_ra, r_sa, r_ds, r_ss, r_op, acc);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
